// File: rtl/uart_tx_frame_if.sv
// Producer-side handshake for uart_tx_frame: level-sensitive valid/ready
// with the data word to serialise.
interface uart_tx_frame_if #(
  parameter int MAX_DATA_W = 9
);
  logic                  iTx_Val;
  logic [MAX_DATA_W-1:0] iData;
  logic                  oTx_Rdy;

  modport master (
    output iTx_Val,
    output iData,
    input  oTx_Rdy
  );

  modport slave (
    input  iTx_Val,
    input  iData,
    output oTx_Rdy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter with runtime divider, 5..MAX_DATA_W data bits and 1/2 stop bits.
// Define UART_TX_PARITY_EN to build the odd/even PARITY state.
module uart_tx_frame #(
  parameter int DIV_W      = 16,
  parameter int MAX_DATA_W = 9
) (
  input  logic              Clk,
  input  logic              Rst_n,
  uart_tx_frame_if.slave    txIf,
  input  logic [DIV_W-1:0]  iBaud_Div,
  input  logic [3:0]        iData_Len,
  input  logic              iStop2,
  input  logic [1:0]        iParity_Mode,
  output logic              oBit,
  output logic              oTx_Done,
  output logic              oBusy
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} txState_t;
`endif

  txState_t              stateReg, stateNext;
  logic [DIV_W-1:0]      cntReg, cntNext;
  logic [DIV_W-1:0]      divReg, divNext;
  logic [3:0]            idxReg, idxNext;
  logic [3:0]            lenReg, lenNext;
  logic [MAX_DATA_W-1:0] shiftReg, shiftNext;
  logic                  stop2Reg, stop2Next;
  logic                  bitReg, bitNext;
  logic                  rdyReg, rdyNext;
  logic                  doneReg, doneNext;
  logic                  busyReg;

  logic [DIV_W-1:0]      divClamp;
  logic [3:0]            lenClamp;
  logic [MAX_DATA_W-1:0] lenMask;
  logic [MAX_DATA_W-1:0] dataMasked;
  logic                  bitEnd;
  logic                  dataLast;
  logic                  stopLast;

`ifdef UART_TX_PARITY_EN
  logic parEnReg, parEnNext;
  logic parBitReg, parBitNext;
`else
  logic unusedParityMode;
  assign unusedParityMode = ^iParity_Mode;
`endif

  assign divClamp = (iBaud_Div < DIV_W'(2)) ? DIV_W'(2) : iBaud_Div;

  always_comb begin
    lenClamp = iData_Len;
    if (iData_Len < 4'd5)
      lenClamp = 4'd5;
    else if (iData_Len > 4'(MAX_DATA_W))
      lenClamp = 4'(MAX_DATA_W);
  end

  // Bits above the frame length are zeroed so they cannot leak into parity.
  generate
    for (genvar gi = 0; gi < MAX_DATA_W; gi++) begin : genLenMask
      assign lenMask[gi] = (4'(gi) < lenClamp);
    end
  endgenerate

  assign dataMasked = txIf.iData & lenMask;
  assign bitEnd     = (cntReg == divReg - DIV_W'(1));
  assign dataLast   = (idxReg == lenReg - 4'd1);
  assign stopLast   = (idxReg == {3'b000, stop2Reg});

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      divReg    <= '0;
      idxReg    <= '0;
      lenReg    <= '0;
      shiftReg  <= '0;
      stop2Reg  <= 1'b0;
      bitReg    <= 1'b1;
      rdyReg    <= 1'b1;
      doneReg   <= 1'b0;
      busyReg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parEnReg  <= 1'b0;
      parBitReg <= 1'b0;
`endif
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      divReg    <= divNext;
      idxReg    <= idxNext;
      lenReg    <= lenNext;
      shiftReg  <= shiftNext;
      stop2Reg  <= stop2Next;
      bitReg    <= bitNext;
      rdyReg    <= rdyNext;
      doneReg   <= doneNext;
      busyReg   <= ~rdyNext;
`ifdef UART_TX_PARITY_EN
      parEnReg  <= parEnNext;
      parBitReg <= parBitNext;
`endif
    end
  end

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    divNext    = divReg;
    idxNext    = idxReg;
    lenNext    = lenReg;
    shiftNext  = shiftReg;
    stop2Next  = stop2Reg;
    bitNext    = bitReg;
    rdyNext    = rdyReg;
    doneNext   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parEnNext  = parEnReg;
    parBitNext = parBitReg;
`endif
    case (stateReg)
      IDLE: begin
        bitNext = 1'b1;
        rdyNext = 1'b1;
        // Frame format is frozen here; later input changes wait for the next word.
        if (txIf.iTx_Val && rdyReg) begin
          stateNext = START;
          bitNext   = 1'b0;
          rdyNext   = 1'b0;
          cntNext   = '0;
          idxNext   = '0;
          shiftNext = dataMasked;
          divNext   = divClamp;
          lenNext   = lenClamp;
          stop2Next = iStop2;
`ifdef UART_TX_PARITY_EN
          parEnNext  = (iParity_Mode == 2'b01) || (iParity_Mode == 2'b10);
          parBitNext = (iParity_Mode == 2'b01) ? ~(^dataMasked) : ^dataMasked;
`endif
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext = DATA;
          cntNext   = '0;
          bitNext   = shiftReg[0];
          shiftNext = shiftReg >> 1;
        end else begin
          cntNext = cntReg + DIV_W'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          cntNext = '0;
          if (dataLast) begin
            idxNext   = '0;
            stateNext = STOP;
            bitNext   = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (parEnReg) begin
              stateNext = PARITY;
              bitNext   = parBitReg;
            end
`endif
          end else begin
            idxNext   = idxReg + 4'd1;
            bitNext   = shiftReg[0];
            shiftNext = shiftReg >> 1;
          end
        end else begin
          cntNext = cntReg + DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          stateNext = STOP;
          cntNext   = '0;
          idxNext   = '0;
          bitNext   = 1'b1;
        end else begin
          cntNext = cntReg + DIV_W'(1);
        end
      end
`endif
      STOP: begin
        bitNext = 1'b1;
        if (bitEnd) begin
          cntNext = '0;
          if (stopLast) begin
            stateNext = IDLE;
            idxNext   = '0;
            rdyNext   = 1'b1;
            doneNext  = 1'b1;
          end else begin
            idxNext = idxReg + 4'd1;
          end
        end else begin
          cntNext = cntReg + DIV_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        bitNext   = 1'b1;
        rdyNext   = 1'b1;
      end
    endcase
  end

  assign oBit         = bitReg;
  assign oTx_Done     = doneReg;
  assign oBusy        = busyReg;
  assign txIf.oTx_Rdy = rdyReg;

endmodule
